// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - memory stage: scalar/vector data access FSM, stall and M->W registers
// Optional MEM_PERF_CNT_EN adds stall and completed-memop counters.
module memory_cycle #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 4,
  parameter int RD_W_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RegWriteM,
  input  logic                    MemWriteM,
  input  logic                    ResultSrcM,
  input  logic                    is_vectorialM,
  input  logic [RD_W_BITS-1:0]    RD_M,
  input  logic [31:0]             PCPlus4M,
  input  logic [31:0]             ALU_ResultM,
  input  logic [LANES*DATA_W-1:0] WriteDataM,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    StallM,
  output logic                    RegWriteW,
  output logic                    ResultSrcW,
  output logic [RD_W_BITS-1:0]    RD_W,
  output logic [31:0]             PCPlus4W,
  output logic [31:0]             ALU_ResultW,
  output logic [LANES*DATA_W-1:0] ReadDataW,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_memop_cnt
);

  localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  stateQ;
  logic [BEAT_W-1:0]       beatQ;
  logic [DATA_W-1:0]       laneQ [LANES];
  logic                    memOp;
  logic                    isLoad;
  logic                    lastBeat;
  logic                    reqPhase;
  logic                    handshake;
  logic                    rspHit;
  logic                    complete;
  logic [LANES*DATA_W-1:0] assembled;

  // A store wins when both MemWriteM and ResultSrcM are set.
  always_comb begin
    memOp     = MemWriteM | ResultSrcM;
    isLoad    = ResultSrcM & ~MemWriteM;
    lastBeat  = is_vectorialM ? (beatQ == BEAT_W'(LANES - 1)) : 1'b1;
    reqPhase  = ~rst & memOp & (stateQ != RESP);
    handshake = reqPhase & mem_req_ready;
    rspHit    = ~rst & (stateQ == RESP) & mem_rsp_valid;
    complete  = ~memOp | (handshake & ~isLoad & lastBeat) | (rspHit & lastBeat);
  end

  assign mem_req_valid = reqPhase;
  assign mem_we        = MemWriteM;
  assign mem_addr      = {ALU_ResultM[31:2] + 30'(beatQ), 2'b00};
  assign mem_wdata     = WriteDataM[DATA_W*int'(beatQ) +: DATA_W];
  assign StallM        = ~rst & memOp & ~complete;

  // Final beat's data bypasses laneQ; scalar loads keep only lane 0.
  always_comb begin
    assembled = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i == 0 || is_vectorialM) begin
        if (rspHit && beatQ == BEAT_W'(i))
          assembled[i*DATA_W +: DATA_W] = mem_rdata;
        else
          assembled[i*DATA_W +: DATA_W] = laneQ[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= IDLE;
      beatQ       <= '0;
      for (int i = 0; i < LANES; i++) laneQ[i] <= '0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else if (complete) begin
      stateQ      <= IDLE;
      beatQ       <= '0;
      for (int i = 0; i < LANES; i++) laneQ[i] <= '0;
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= isLoad ? assembled : '0;
    end else begin
      case (stateQ)
        IDLE, ISSUE: begin
          if (handshake) begin
            if (isLoad) begin
              stateQ <= RESP;
            end else begin
              beatQ  <= beatQ + 1'b1;
              stateQ <= ISSUE;
            end
          end else begin
            stateQ <= ISSUE;
          end
        end
        RESP: begin
          if (rspHit) begin
            laneQ[beatQ] <= mem_rdata;
            beatQ        <= beatQ + 1'b1;
            stateQ       <= ISSUE;
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_memop_cnt <= '0;
    end else begin
      if (StallM)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (memOp && complete)
        perf_memop_cnt <= perf_memop_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_memop_cnt = '0;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - directed self-checking bench for memory_cycle
module tb_memory_cycle;

  logic         clk = 1'b0;
  logic         rst;
  logic         RegWriteM, MemWriteM, ResultSrcM, is_vectorialM;
  logic [5:0]   RD_M;
  logic [31:0]  PCPlus4M, ALU_ResultM;
  logic [127:0] WriteDataM;
  logic         mem_req_valid, mem_req_ready, mem_we;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rdata;
  logic         StallM, RegWriteW, ResultSrcW;
  logic [5:0]   RD_W;
  logic [31:0]  PCPlus4W, ALU_ResultW;
  logic [127:0] ReadDataW;
  logic [31:0]  perf_stall_cnt, perf_memop_cnt;

  int checks = 0;
  int errors = 0;
  int stalls;
  logic [31:0] vAddr [4];
  logic [31:0] vData [4];

  always #5 clk = ~clk;

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .is_vectorialM(is_vectorialM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RD_W(RD_W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW),
    .perf_stall_cnt(perf_stall_cnt), .perf_memop_cnt(perf_memop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearM();
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; is_vectorialM = 1'b0;
    RD_M = '0; PCPlus4M = '0; ALU_ResultM = '0; WriteDataM = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    vAddr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    vData = '{32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    rst = 1'b1;
    clearM();
    tick();
    // memop presented during reset must not request or stall
    ResultSrcM = 1'b1; mem_req_ready = 1'b1;
    #1;
    chk("rst_req_valid", 128'(mem_req_valid), 128'(0));
    chk("rst_stall", 128'(StallM), 128'(0));
    tick();
    chk("rst_regwritew", 128'(RegWriteW), 128'(0));
    chk("rst_aluw", 128'(ALU_ResultW), 128'(0));
    chk("rst_readdataw", ReadDataW, 128'(0));

    // non-memory op
    rst = 1'b0; clearM();
    RegWriteM = 1'b1; RD_M = 6'd1; ALU_ResultM = 32'd30; PCPlus4M = 32'h44;
    #1;
    chk("alu_stall", 128'(StallM), 128'(0));
    chk("alu_req_valid", 128'(mem_req_valid), 128'(0));
    tick();
    chk("alu_aluw", 128'(ALU_ResultW), 128'(30));
    chk("alu_rdw", 128'(RD_W), 128'(1));
    chk("alu_regwritew", 128'(RegWriteW), 128'(1));
    chk("alu_pcw", 128'(PCPlus4W), 128'(32'h44));
    chk("alu_readdataw", ReadDataW, 128'(0));

    // scalar load, response one cycle after handshake
    clearM();
    ResultSrcM = 1'b1; RegWriteM = 1'b1; RD_M = 6'd5; ALU_ResultM = 32'h100; mem_req_ready = 1'b1;
    #1;
    chk("sld_req_valid", 128'(mem_req_valid), 128'(1));
    chk("sld_addr", 128'(mem_addr), 128'(32'h100));
    chk("sld_we", 128'(mem_we), 128'(0));
    chk("sld_stall0", 128'(StallM), 128'(1));
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("sld_resp_req_valid", 128'(mem_req_valid), 128'(0));
    chk("sld_stall1", 128'(StallM), 128'(0));
    tick();
    chk("sld_readdataw", ReadDataW, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    chk("sld_rdw", 128'(RD_W), 128'(5));
    chk("sld_resultsrcw", 128'(ResultSrcW), 128'(1));

    // vector store, ready held low 2 cycles on beat 0
    clearM();
    MemWriteM = 1'b1; is_vectorialM = 1'b1; ALU_ResultM = 32'h200;
    WriteDataM = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
    stalls = 0;
    for (int c = 0; c < 2; c++) begin
      mem_rsp_valid = (c == 1);
      #1;
      chk("vst_wait_valid", 128'(mem_req_valid), 128'(1));
      chk("vst_wait_addr", 128'(mem_addr), 128'(32'h200));
      chk("vst_wait_wdata", 128'(mem_wdata), 128'(32'h4));
      stalls += int'(StallM);
      tick();
    end
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("vst_valid", 128'(mem_req_valid), 128'(1));
      chk("vst_we", 128'(mem_we), 128'(1));
      chk("vst_addr", 128'(mem_addr), 128'(32'h200 + 32'(4 * b)));
      chk("vst_wdata", 128'(mem_wdata), 128'(vData[b]));
      stalls += int'(StallM);
      tick();
    end
    chk("vst_stalls", 128'(stalls), 128'(5));
    chk("vst_readdataw", ReadDataW, 128'(0));

    // vector load with address wrap
    clearM();
    ResultSrcM = 1'b1; is_vectorialM = 1'b1; RegWriteM = 1'b1; RD_M = 6'd7; ALU_ResultM = 32'hFFFF_FFF8;
    stalls = 0;
    for (int b = 0; b < 4; b++) begin
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
      #1;
      chk("vld_valid", 128'(mem_req_valid), 128'(1));
      chk("vld_addr", 128'(mem_addr), 128'(vAddr[b]));
      stalls += int'(StallM);
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(b);
      #1;
      chk("vld_resp_valid", 128'(mem_req_valid), 128'(0));
      stalls += int'(StallM);
      tick();
    end
    chk("vld_stalls", 128'(stalls), 128'(7));
    chk("vld_readdataw", ReadDataW, 128'hA000_0003_A000_0002_A000_0001_A000_0000);
    chk("vld_rdw", 128'(RD_W), 128'(7));

    // scalar load right after a vector load: lanes 1..3 zero-filled
    clearM();
    ResultSrcM = 1'b1; RegWriteM = 1'b1; RD_M = 6'd2; ALU_ResultM = 32'h10; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    chk("sld2_readdataw", ReadDataW, 128'h0000_0000_0000_0000_0000_0000_1234_5678);

    // reset during RESP of beat 2
    clearM();
    ResultSrcM = 1'b1; is_vectorialM = 1'b1; RegWriteM = 1'b1; RD_M = 6'd9; ALU_ResultM = 32'h300;
    for (int b = 0; b < 2; b++) begin
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hB000_0000 + 32'(b); tick();
    end
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; tick();
    rst = 1'b1; mem_req_ready = 1'b0;
    #1;
    chk("mrst_stall", 128'(StallM), 128'(0));
    chk("mrst_req_valid", 128'(mem_req_valid), 128'(0));
    tick();
    chk("mrst_regwritew", 128'(RegWriteW), 128'(0));
    chk("mrst_rdw", 128'(RD_W), 128'(0));
    chk("mrst_readdataw", ReadDataW, 128'(0));
    rst = 1'b0; clearM();
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("stray_stall", 128'(StallM), 128'(0));
    chk("stray_req_valid", 128'(mem_req_valid), 128'(0));
    tick();
    chk("stray_readdataw", ReadDataW, 128'(0));
    chk("stray_resultsrcw", 128'(ResultSrcW), 128'(0));

    // stray responses while a load waits for ready are ignored
    ResultSrcM = 1'b1; RegWriteM = 1'b1; RD_M = 6'd3; ALU_ResultM = 32'h40;
    #1;
    chk("idle_stray_valid", 128'(mem_req_valid), 128'(1));
    chk("idle_stray_stall", 128'(StallM), 128'(1));
    tick();
    chk("issue_stray_stall", 128'(StallM), 128'(1));
    tick();
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    chk("late_rsp_stall", 128'(StallM), 128'(0));
    tick();
    chk("late_readdataw", ReadDataW, 128'h0000_0000_0000_0000_0000_0000_5555_AAAA);

    // scalar load then scalar store, counters from a fresh reset
    rst = 1'b1; clearM(); tick();
    rst = 1'b0;
    ResultSrcM = 1'b1; ALU_ResultM = 32'h80; mem_req_ready = 1'b1; tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0011; tick();
    clearM();
    MemWriteM = 1'b1; ALU_ResultM = 32'h84; WriteDataM = 128'hFFFF_0000_EEEE_0000_DDDD_0000_CAFE_F00D;
    mem_req_ready = 1'b1;
    #1;
    chk("sst_stall", 128'(StallM), 128'(0));
    chk("sst_we", 128'(mem_we), 128'(1));
    chk("sst_wdata", 128'(mem_wdata), 128'(32'hCAFE_F00D));
    tick();
    clearM();
    #1;
`ifdef MEM_PERF_CNT_EN
    chk("perf_stall_cnt", 128'(perf_stall_cnt), 128'(1));
    chk("perf_memop_cnt", 128'(perf_memop_cnt), 128'(2));
`else
    chk("perf_stall_cnt", 128'(perf_stall_cnt), 128'(0));
    chk("perf_memop_cnt", 128'(perf_memop_cnt), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
